// File: rtl/fp_unpack_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fp_unpack_seq
//  Purpose  : Handshaked FP operand unpacker. Checks the NaN-box, splits the
//             operand into sign / unbiased exponent / significand with an
//             explicit leading one, and produces the RISC-V fclass mask.
//             Subnormals are normalised over several cycles, at most
//             SHIFT_STEP bit positions per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module fp_unpack_seq #(
   parameter int IN_LEN     = 32,
   parameter int FLEN       = 32,
   parameter int EXP_LEN    = 8,
   parameter int SIG_LEN    = 23,
   parameter int SHIFT_STEP = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [IN_LEN-1:0]    data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 sign_o,
   output logic [EXP_LEN+1:0]   exp_o,
   output logic [SIG_LEN:0]     sig_o,
   output logic [9:0]           class_o
);

   localparam int BIAS = 2**(EXP_LEN-1) - 1;
   localparam int EW   = EXP_LEN + 2;
   localparam int RW   = $clog2(SIG_LEN + 1);

   localparam logic signed [EW-1:0] C_BIAS        = EW'(BIAS);
   localparam logic signed [EW-1:0] C_EXP_SPECIAL = EW'(BIAS + 1);
   localparam logic signed [EW-1:0] C_EXP_ZERO    = EW'(-BIAS);
   localparam logic signed [EW-1:0] C_EXP_SUB_MAX = EW'(1 - BIAS);
   localparam logic [RW-1:0]        C_STEP        = RW'(SHIFT_STEP);
   localparam logic [FLEN-1:0]      C_CANON_QNAN  =
      {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(SIG_LEN-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic                 sign_q, sign_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic [SIG_LEN:0]     sig_q, sig_d;
   logic [9:0]           class_q, class_d;
   logic [RW-1:0]        rem_q, rem_d;

   logic                 w_box_ok;
   logic [FLEN-1:0]      w_operand;
   logic                 w_sign;
   logic [EXP_LEN-1:0]   w_exp_fld;
   logic [SIG_LEN-1:0]   w_frac;
   logic [RW-1:0]        w_lz;
   logic                 w_dec_sub;
   logic signed [EW-1:0] w_dec_exp;
   logic [SIG_LEN:0]     w_dec_sig;
   logic [9:0]           w_dec_class;
   logic [RW-1:0]        w_step;
   logic                 w_accept;

   // A register wider than the format must carry an all-ones box, otherwise
   // the operand is replaced by the canonical quiet NaN.
   if (IN_LEN > FLEN) begin : g_nanbox
      assign w_box_ok = &data_i[IN_LEN-1:FLEN];
   end else begin : g_no_nanbox
      assign w_box_ok = 1'b1;
   end

   assign w_operand = w_box_ok ? data_i[FLEN-1:0] : C_CANON_QNAN;
   assign w_sign    = w_operand[FLEN-1];
   assign w_exp_fld = w_operand[FLEN-2:SIG_LEN];
   assign w_frac    = w_operand[SIG_LEN-1:0];

   assign ready_o   = (state_q == ST_IDLE) | ((state_q == ST_DONE) & ready_i);
   assign w_accept  = valid_i & ready_o;
   assign w_step    = (rem_q < C_STEP) ? rem_q : C_STEP;

   // Normalisation distance of a subnormal: SIG_LEN minus the fraction's MSB index.
   always_comb begin
      w_lz = '0;
      for (int i = 0; i < SIG_LEN; i++) begin
         if (w_frac[i]) w_lz = RW'(SIG_LEN - i);
      end
   end

   // Classify the operand and form its unpacked fields (subnormals pre-shift).
   always_comb begin
      w_dec_sub   = 1'b0;
      w_dec_exp   = $signed({2'b00, w_exp_fld}) - C_BIAS;
      w_dec_sig   = {1'b1, w_frac};
      w_dec_class = '0;
      if (&w_exp_fld) begin
         w_dec_exp = C_EXP_SPECIAL;
         if (w_frac == '0) begin
            w_dec_class = w_sign ? 10'h001 : 10'h080;
         end else begin
            w_dec_class = w_frac[SIG_LEN-1] ? 10'h200 : 10'h100;
         end
      end else if (w_exp_fld != '0) begin
         w_dec_class = w_sign ? 10'h002 : 10'h040;
      end else if (w_frac == '0) begin
         w_dec_exp   = C_EXP_ZERO;
         w_dec_sig   = '0;
         w_dec_class = w_sign ? 10'h008 : 10'h010;
      end else begin
         w_dec_sub   = 1'b1;
         w_dec_exp   = C_EXP_SUB_MAX - $signed({{(EW-RW){1'b0}}, w_lz});
         w_dec_sig   = {1'b0, w_frac};
         w_dec_class = w_sign ? 10'h004 : 10'h020;
      end
   end

   // Next-state and result datapath: load on accept, shift while normalising.
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      sig_d   = sig_q;
      class_d = class_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               sign_d  = w_sign;
               exp_d   = w_dec_exp;
               sig_d   = w_dec_sig;
               class_d = w_dec_class;
               rem_d   = w_dec_sub ? w_lz : '0;
               state_d = w_dec_sub ? ST_NORM : ST_DONE;
            end else if ((state_q == ST_DONE) && ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_NORM: begin
            sig_d = sig_q << w_step;
            rem_d = rem_q - w_step;
            if (rem_q <= C_STEP) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         sig_q   <= '0;
         class_q <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         sig_q   <= sig_d;
         class_q <= class_d;
         rem_q   <= rem_d;
      end
   end

   assign valid_o = (state_q == ST_DONE);
   assign sign_o  = sign_q;
   assign exp_o   = exp_q;
   assign sig_o   = sig_q;
   assign class_o = class_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_unpack_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_unpack_seq
//  Purpose  : Self-checking bench for fp_unpack_seq (FP32 in a 64-bit
//             NaN-boxed register) against a value-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fp_unpack_seq;

   logic        clk_i = 1'b0;
   logic        rst_i, valid_i, ready_i;
   logic [63:0] data_i;
   logic        ready_o, valid_o, sign_o;
   logic [9:0]  exp_o;
   logic [23:0] sig_o;
   logic [9:0]  class_o;

   int total = 0;
   int bad   = 0;

   fp_unpack_seq #(.IN_LEN(64), .FLEN(32), .EXP_LEN(8), .SIG_LEN(23), .SHIFT_STEP(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .sign_o(sign_o),
      .exp_o(exp_o), .sig_o(sig_o), .class_o(class_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        sign;
      int          ex;
      logic [23:0] sig;
      logic [9:0]  cls;
      int          lat;
   } res_t;

   // Value-level reference: classify the FP32 number and normalise it.
   function automatic res_t model(input logic [63:0] raw);
      res_t        r;
      logic [31:0] v;
      int          e;
      int          s;
      logic [22:0] f;
      logic [23:0] m;
      v = (raw[63:32] == 32'hFFFF_FFFF) ? raw[31:0] : 32'h7FC0_0000;
      r.sign = v[31];
      e = int'(v[30:23]);
      f = v[22:0];
      r.lat = 1;
      if (e == 255) begin
         r.ex = 128;
         r.sig = {1'b1, f};
         if (f == 0) r.cls = r.sign ? 10'h001 : 10'h080;
         else        r.cls = f[22] ? 10'h200 : 10'h100;
      end else if (e != 0) begin
         r.ex = e - 127;
         r.sig = {1'b1, f};
         r.cls = r.sign ? 10'h002 : 10'h040;
      end else if (f == 0) begin
         r.ex = -127;
         r.sig = 24'h0;
         r.cls = r.sign ? 10'h008 : 10'h010;
      end else begin
         m = {1'b0, f};
         s = 0;
         while (!m[23]) begin
            m = m << 1;
            s++;
         end
         r.ex = -126 - s;
         r.sig = m;
         r.cls = r.sign ? 10'h004 : 10'h020;
         r.lat = 1 + (s + 3) / 4;
      end
      return r;
   endfunction

   function automatic logic [44:0] pack(input res_t r);
      logic [31:0] e32;
      e32 = r.ex;
      return {r.sign, e32[9:0], r.sig, r.cls};
   endfunction

   function automatic logic [63:0] rand_op();
      logic [31:0] v;
      logic [31:0] hi;
      int          k;
      v  = $urandom;
      hi = 32'hFFFF_FFFF;
      k  = $urandom_range(0, 5);
      case (k)
         0: v[30:23] = 8'($urandom_range(1, 254));
         1: begin
            v[30:23] = 8'h00;
            v[22:0]  = v[22:0] >> $urandom_range(0, 22);
            if (v[22:0] == 0) v[0] = 1'b1;
         end
         2: v[30:0] = 31'h0;
         3: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
         4: v[30:23] = 8'hFF;
         default: begin hi = $urandom; hi[$urandom_range(0, 31)] = 1'b0; end
      endcase
      return {hi, v};
   endfunction

   // Drive one operand (DUT ready assumed, ready_i=1) and wait for its result.
   task automatic do_op(input logic [63:0] raw, output logic [44:0] got, output int lat);
      data_i = raw; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (!valid_o) lat = -1;
      got = {sign_o, exp_o, sig_o, class_o};
   endtask

   task automatic idle();
      valid_i = 1'b0; ready_i = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_reset();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
      total++;
      if ({sign_o, exp_o, sig_o, class_o} !== 45'h0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0", {sign_o, exp_o, sig_o, class_o});
      end
   endtask

   task automatic test_normal();
      logic [63:0] ops[$];
      logic [44:0] got;
      int          lat;
      res_t        r;
      logic [31:0] v;
      ops.push_back(64'hFFFF_FFFF_3F80_0000);
      for (int i = 0; i < 15; i++) begin
         v = $urandom; v[30:23] = 8'($urandom_range(1, 254));
         ops.push_back({32'hFFFF_FFFF, v});
      end
      idle();
      foreach (ops[i]) begin
         r = model(ops[i]);
         do_op(ops[i], got, lat);
         total++; if (got !== pack(r)) begin bad++; $display("FAIL normal_fields op=%h got=%h exp=%h", ops[i], got, pack(r)); end
         total++; if (lat !== r.lat) begin bad++; $display("FAIL normal_latency op=%h got=%0d exp=%0d", ops[i], lat, r.lat); end
      end
   endtask

   task automatic test_subnormal();
      logic [44:0] got;
      int          lat;
      res_t        r;
      logic [63:0] op;
      logic [31:0] v;
      idle();
      op = 64'hFFFF_FFFF_0000_0001;
      r = model(op);
      data_i = op; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         total++;
         if (ready_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL norm_busy cycle=%0d got ready=%b valid=%b exp ready=0 valid=0", c, ready_o, valid_o);
         end
         @(posedge clk_i); #1;
      end
      got = {sign_o, exp_o, sig_o, class_o};
      total++;
      if (valid_o !== 1'b1 || got !== pack(r)) begin
         bad++; $display("FAIL min_subnormal got valid=%b %h exp valid=1 %h", valid_o, got, pack(r));
      end
      for (int i = 0; i < 12; i++) begin
         v = $urandom; v[30:23] = 8'h00;
         v[22:0] = v[22:0] >> $urandom_range(0, 22);
         if (v[22:0] == 0) v[0] = 1'b1;
         op = {32'hFFFF_FFFF, v};
         r = model(op);
         do_op(op, got, lat);
         total++; if (got !== pack(r)) begin bad++; $display("FAIL subnormal_fields op=%h got=%h exp=%h", op, got, pack(r)); end
         total++; if (lat !== r.lat) begin bad++; $display("FAIL subnormal_latency op=%h got=%0d exp=%0d", op, lat, r.lat); end
      end
   endtask

   task automatic test_specials();
      logic [31:0] ops[8] = '{32'h8040_0000, 32'hFF80_0000, 32'h8000_0000, 32'h7FC0_0000,
                              32'h7F80_0000, 32'h0000_0000, 32'h7F80_0001, 32'hFFC0_0000};
      logic [44:0] got;
      int          lat;
      res_t        r;
      idle();
      foreach (ops[i]) begin
         r = model({32'hFFFF_FFFF, ops[i]});
         do_op({32'hFFFF_FFFF, ops[i]}, got, lat);
         total++; if (got !== pack(r)) begin bad++; $display("FAIL special_fields op=%h got=%h exp=%h", ops[i], got, pack(r)); end
         total++; if (lat !== r.lat) begin bad++; $display("FAIL special_latency op=%h got=%0d exp=%0d", ops[i], lat, r.lat); end
      end
   endtask

   task automatic test_nanbox();
      logic [63:0] ops[3] = '{64'hFFFF_FFFF_7F80_0001, 64'h0000_0000_3F80_0000, 64'h7FFF_FFFF_BF80_0000};
      logic [44:0] got;
      int          lat;
      res_t        r;
      idle();
      foreach (ops[i]) begin
         r = model(ops[i]);
         do_op(ops[i], got, lat);
         total++; if (got !== pack(r)) begin bad++; $display("FAIL nanbox op=%h got=%h exp=%h", ops[i], got, pack(r)); end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] ops[$];
      logic [63:0] op;
      res_t        r;
      while (ops.size() < 8) begin
         op = rand_op();
         r = model(op);
         if (r.lat == 1) ops.push_back(op);
      end
      idle();
      data_i = ops[0]; valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_i); #1;
         r = model(ops[i]);
         total++;
         if (valid_o !== 1'b1 || {sign_o, exp_o, sig_o, class_o} !== pack(r)) begin
            bad++; $display("FAIL b2b_result idx=%0d got valid=%b %h exp valid=1 %h", i, valid_o, {sign_o, exp_o, sig_o, class_o}, pack(r));
         end
         total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, ready_o); end
         if (i < 7) data_i = ops[i+1];
         else valid_i = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] a, b;
      logic [31:0] v;
      v = $urandom; v[30:23] = 8'($urandom_range(1, 254)); a = {32'hFFFF_FFFF, v};
      v = $urandom; v[30:23] = 8'($urandom_range(1, 254)); b = {32'hFFFF_FFFF, v};
      idle();
      data_i = a; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i); #1;
      data_i = b;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || {sign_o, exp_o, sig_o, class_o} !== pack(model(a))) begin
            bad++; $display("FAIL backpressure_hold k=%0d got valid=%b ready=%b %h exp valid=1 ready=0 %h",
                            k, valid_o, ready_o, {sign_o, exp_o, sig_o, class_o}, pack(model(a)));
         end
         @(posedge clk_i); #1;
      end
      ready_i = 1'b1; #1;
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL backpressure_release got=%b exp=1", ready_o); end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      total++;
      if (valid_o !== 1'b1 || {sign_o, exp_o, sig_o, class_o} !== pack(model(b))) begin
         bad++; $display("FAIL backpressure_next got valid=%b %h exp valid=1 %h", valid_o, {sign_o, exp_o, sig_o, class_o}, pack(model(b)));
      end
      @(posedge clk_i); #1;
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL backpressure_drain got=%b exp=0", valid_o); end
   endtask

   task automatic test_reset_mid_norm();
      logic stale;
      idle();
      data_i = 64'hFFFF_FFFF_0000_0001; valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || {sign_o, exp_o, sig_o, class_o} !== 45'h0) begin
         bad++; $display("FAIL reset_mid_norm got valid=%b ready=%b %h exp valid=0 ready=1 0", valid_o, ready_o, {sign_o, exp_o, sig_o, class_o});
      end
      stale = 1'b0;
      repeat (12) begin
         @(posedge clk_i); #1;
         if (valid_o) stale = 1'b1;
      end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL reset_stale_result got=%b exp=0", stale); end
   endtask

   task automatic test_stream();
      res_t        q[$];
      res_t        e;
      logic [63:0] op;
      logic        have;
      int          n;
      have = 1'b0;
      op = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!have && $urandom_range(0, 1) == 1) begin op = rand_op(); have = 1'b1; end
         valid_i = have; data_i = op; ready_i = ($urandom_range(0, 3) != 0);
         #1;
         if (valid_o) begin
            total++; if ($countones(class_o) != 1) begin bad++; $display("FAIL stream_onehot got=%h exp=one-hot", class_o); end
         end
         if (valid_o && ready_i) begin
            total++;
            if (q.size() == 0) begin
               bad++; $display("FAIL stream_unexpected got valid=1 exp no result pending");
            end else begin
               e = q.pop_front();
               if ({sign_o, exp_o, sig_o, class_o} !== pack(e)) begin
                  bad++; $display("FAIL stream_result got=%h exp=%h", {sign_o, exp_o, sig_o, class_o}, pack(e));
               end
            end
         end
         if (valid_i && ready_o) begin q.push_back(model(op)); have = 1'b0; end
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0; ready_i = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 100) begin
         if (valid_o) begin
            e = q.pop_front();
            total++;
            if ({sign_o, exp_o, sig_o, class_o} !== pack(e)) begin
               bad++; $display("FAIL stream_drain got=%h exp=%h", {sign_o, exp_o, sig_o, class_o}, pack(e));
            end
         end
         @(posedge clk_i); #1;
         n++;
      end
      total++; if (q.size() != 0) begin bad++; $display("FAIL stream_timeout got pending=%0d exp=0", q.size()); end
   endtask

   initial begin
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      test_reset();
      rst_i = 1'b0;
      test_normal();
      test_subnormal();
      test_specials();
      test_nanbox();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_norm();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
